exec_core: RTL and testbench
============================

// Module: exec_core
// PURPOSE
//  Execution core of the single-cycle RV32I datapath: a 32-entry register file plus a combinational ALU.
//  ALU op1 = rs1 data; op2 = rs2 data or the supplied immediate, selected by alu_src.
//  Write-back data comes from the datapath (ALU result or load data) and commits on the clock edge.
//  Sits between the instruction decode/immediate logic and the data-memory interface.
// PARAMETERS
//  DATAWIDTH  32  width of registers, ALU operands and result
// PORTS
//  clk         in   1          single clock; register writes on posedge
//  rst         in   1          asynchronous, active-low reset; clears every register
//  readReg1    in   5          rs1 address
//  readReg2    in   5          rs2 address
//  writeReg    in   5          rd address
//  writeData   in   DATAWIDTH  write-back data
//  write       in   1          register write enable
//  imm         in   DATAWIDTH  sign-extended immediate from decode
//  alu_src     in   1          1: op2=imm, 0: op2=readData2
//  alu_op      in   4          ALU operation code
//  readData1   out  DATAWIDTH  rs1 data (combinational)
//  readData2   out  DATAWIDTH  rs2 data (combinational; store data)
//  result      out  DATAWIDTH  ALU result (combinational)
//  zero        out  1          1 when result == 0
// BEHAVIOUR
//  Register file:
//  - Storage is an array named registers[0:31], accessible hierarchically.
//  - rst low, asynchronously: all 32 entries = 0. Entries hold 0 while rst is low.
//  - Posedge clk, write=1, writeReg!=0: registers[writeReg] <= writeData.
//  - Writes to x0 are ignored. Reads of x0 always return 0.
//  - Reads are combinational.
//  - Same-cycle read of the register being written returns the OLD value; the new value is visible after the edge.
//  ALU, combinational (a=readData1, b=op2; shift amount = b[4:0]):
//  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0101 XOR.
//  - 0100 SLT: signed a<b gives 1, else 0.
//  - 1000 SRL; 1001 SLL; 1010 SRA (arithmetic, sign-filled).
//  - Any other code: result = 0.
//  - ADD/SUB wrap modulo 2^DATAWIDTH; no overflow flag.
//  - zero = (result == 0), including for undefined codes.
//  Outputs:
//  - readData1/readData2/result/zero are combinational, with no reset value of their own.
//  - During reset, reads return 0, so ADD gives result=0 and zero=1.
//  - No handshake; zero-cycle latency from address/op change to outputs.
// STRUCTURE
//  - Shared package rv_pkg: ALU op localparams (ALUOP_AND..ALUOP_SRA), OPCODE_* constants, NUM_REGS=32.
//  - One sub-module: regfile (storage and read ports). ALU is inline combinational logic in exec_core.
// TESTING
//  - Reset: pulse rst low mid-run after writes -> every readData returns 0 immediately, before any clock.
//  - Write/read: write x5=32'h1234_5678 -> readReg1=5 gives 32'h1234_5678.
//  - x0: write x0=32'hFFFF_FFFF -> readReg1=0 gives 0.
//  - Bypass: read x7 in the same cycle it is written -> old value; new value after posedge.
//  - Arithmetic: x1=5, x2=7, SUB -> 32'hFFFF_FFFE, zero=0; SLT -> 1.
//  - SLT signed: x1=32'h8000_0000, x2=1 -> SLT gives 1.
//  - Immediate and shifts: x1=32'h8000_0000, alu_src=1, imm=4:
//      SRA -> 32'hF800_0000; SRL -> 32'h0800_0000; SLL -> 0 with zero=1.
//  - Zero flag: x1=9, x2=9, SUB -> result=0, zero=1.
//  - Undefined code: alu_op=4'b1111 -> result=0, zero=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: ALU operation codes, base opcodes and register-file size.
package rv_pkg;
    localparam int NUM_REGS = 32;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SLT = 4'b0100;
    localparam logic [3:0] ALUOP_XOR = 4'b0101;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
endpackage

// File: rtl/exec_core_regfile.sv
// 32-entry register file: two combinational read ports, one write port on posedge, x0 hardwired to 0.
module regfile
    import rv_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           readReg1,
    input  logic [4:0]           readReg2,
    input  logic [4:0]           writeReg,
    input  logic [DATAWIDTH-1:0] writeData,
    input  logic                 write,
    output logic [DATAWIDTH-1:0] readData1,
    output logic [DATAWIDTH-1:0] readData2
);
    logic [DATAWIDTH-1:0] registers [0:NUM_REGS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) registers[i] <= '0;
        end else if (write && (writeReg != 5'd0)) begin
            registers[writeReg] <= writeData;
        end
    end

    // No write-to-read forwarding: a same-cycle read sees the pre-edge contents.
    always_comb begin
        readData1 = (readReg1 == 5'd0) ? '0 : registers[readReg1];
        readData2 = (readReg2 == 5'd0) ? '0 : registers[readReg2];
    end
endmodule

// File: rtl/exec_core.sv
// Single-cycle RV32I execution core: register file feeding a combinational ALU.
module exec_core
    import rv_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           readReg1,
    input  logic [4:0]           readReg2,
    input  logic [4:0]           writeReg,
    input  logic [DATAWIDTH-1:0] writeData,
    input  logic                 write,
    input  logic [DATAWIDTH-1:0] imm,
    input  logic                 alu_src,
    input  logic [3:0]           alu_op,
    output logic [DATAWIDTH-1:0] readData1,
    output logic [DATAWIDTH-1:0] readData2,
    output logic [DATAWIDTH-1:0] result,
    output logic                 zero
);
    logic [DATAWIDTH-1:0] op2;
    logic [4:0]           shamt;

    regfile #(.DATAWIDTH(DATAWIDTH)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .write     (write),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    always_comb begin
        op2   = alu_src ? imm : readData2;
        shamt = op2[4:0];
        case (alu_op)
            ALUOP_AND: result = readData1 & op2;
            ALUOP_OR:  result = readData1 | op2;
            ALUOP_ADD: result = readData1 + op2;
            ALUOP_SUB: result = readData1 - op2;
            ALUOP_XOR: result = readData1 ^ op2;
            ALUOP_SLT: result = {{(DATAWIDTH-1){1'b0}}, $signed(readData1) < $signed(op2)};
            ALUOP_SRL: result = readData1 >> shamt;
            ALUOP_SLL: result = readData1 << shamt;
            ALUOP_SRA: result = $unsigned($signed(readData1) >>> shamt);
            default:   result = '0;
        endcase
        zero = (result == '0);
    end
endmodule

// File: tb/tb_exec_core.sv
// Randomized and directed self-checking bench for exec_core against an arithmetic reference model.
module tb_exec_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData, imm;
    logic        write, alu_src;
    logic [3:0]  alu_op;
    logic [31:0] readData1, readData2, result;
    logic        zero;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] model [32];

    exec_core #(.DATAWIDTH(32)) dut (
        .clk(clk), .rst(rst), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData), .write(write), .imm(imm),
        .alu_src(alu_src), .alu_op(alu_op), .readData1(readData1),
        .readData2(readData2), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        int sa, sb, sh;
        sa = a; sb = b; sh = int'(b % 32);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd5:  return a ^ b;
            4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return a >> sh;
            4'd9:  return a << sh;
            4'd10: return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_write(input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        writeReg = rd; writeData = d; write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        if (rd != 5'd0) model[rd] = d;
    endtask

    task automatic set_ops(input logic [4:0] r1, input logic [4:0] r2, input logic src,
                           input logic [31:0] im, input logic [3:0] op);
        readReg1 = r1; readReg2 = r2; alu_src = src; imm = im; alu_op = op;
        #1;
    endtask

    task automatic test_reset;
        do_write(5'd3, 32'hDEAD_BEEF);
        do_write(5'd31, 32'h0000_0042);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i); readReg2 = 5'(31 - i); alu_op = 4'b0010; alu_src = 1'b0;
            #1;
            vectors++;
            if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_read x%0d: got %h/%h want 0", i, readData1, readData2);
            end
        end
        vectors++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_add: result=%h zero=%b want 0/1", result, zero);
        end
        // Entries must stay cleared across edges while held in reset.
        do_write(5'd3, 32'h1111_1111);
        model[3] = 32'd0;
        set_ops(5'd3, 5'd0, 1'b0, 32'd0, 4'b0010);
        vectors++;
        if (readData1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h want 0", readData1);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        do_write(5'd5, 32'h1234_5678);
        set_ops(5'd5, 5'd0, 1'b0, 32'd0, 4'b0010);
        vectors++;
        if (readData1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_read: got %h want 12345678", readData1);
        end
    endtask

    task automatic test_x0;
        do_write(5'd0, 32'hFFFF_FFFF);
        set_ops(5'd0, 5'd0, 1'b0, 32'd0, 4'b0001);
        vectors++;
        if (readData1 !== 32'd0 || readData2 !== 32'd0 || result !== 32'd0) begin
            errors++;
            $display("FAIL x0: got %h/%h/%h want 0", readData1, readData2, result);
        end
    endtask

    task automatic test_bypass;
        do_write(5'd7, 32'hAAAA_0001);
        @(negedge clk);
        writeReg = 5'd7; writeData = 32'h5555_0002; write = 1'b1;
        set_ops(5'd7, 5'd7, 1'b0, 32'd0, 4'b0010);
        vectors++;
        if (readData1 !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL bypass_old: got %h want aaaa0001", readData1);
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        model[7] = 32'h5555_0002;
        vectors++;
        if (readData1 !== 32'h5555_0002 || readData2 !== 32'h5555_0002) begin
            errors++;
            $display("FAIL bypass_new: got %h/%h want 55550002", readData1, readData2);
        end
    endtask

    task automatic test_arith;
        do_write(5'd1, 32'd5);
        do_write(5'd2, 32'd7);
        set_ops(5'd1, 5'd2, 1'b0, 32'd0, 4'b0110);
        vectors++;
        if (result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7: got %h z=%b want fffffffe z=0", result, zero);
        end
        set_ops(5'd1, 5'd2, 1'b0, 32'd0, 4'b0100);
        vectors++;
        if (result !== 32'd1) begin
            errors++;
            $display("FAIL slt_5_7: got %h want 1", result);
        end
        do_write(5'd1, 32'h8000_0000);
        do_write(5'd2, 32'd1);
        set_ops(5'd1, 5'd2, 1'b0, 32'd0, 4'b0100);
        vectors++;
        if (result !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed: got %h want 1", result);
        end
        set_ops(5'd2, 5'd1, 1'b0, 32'd0, 4'b0100);
        vectors++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL slt_signed_rev: got %h z=%b want 0 z=1", result, zero);
        end
    endtask

    task automatic test_imm_shifts;
        do_write(5'd1, 32'h8000_0000);
        set_ops(5'd1, 5'd2, 1'b1, 32'd4, 4'b1010);
        vectors++;
        if (result !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra_imm: got %h want f8000000", result);
        end
        set_ops(5'd1, 5'd2, 1'b1, 32'd4, 4'b1000);
        vectors++;
        if (result !== 32'h0800_0000) begin
            errors++;
            $display("FAIL srl_imm: got %h want 08000000", result);
        end
        set_ops(5'd1, 5'd2, 1'b1, 32'd4, 4'b1001);
        vectors++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sll_imm: got %h z=%b want 0 z=1", result, zero);
        end
    endtask

    task automatic test_zero_undef;
        do_write(5'd1, 32'd9);
        do_write(5'd2, 32'd9);
        set_ops(5'd1, 5'd2, 1'b0, 32'd0, 4'b0110);
        vectors++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_sub: got %h z=%b want 0 z=1", result, zero);
        end
        set_ops(5'd1, 5'd2, 1'b0, 32'd0, 4'b1111);
        vectors++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL undef_op: got %h z=%b want 0 z=1", result, zero);
        end
    endtask

    task automatic test_random;
        logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd5, 4'd4, 4'd8, 4'd9, 4'd10, 4'd15};
        logic [4:0]  r1, r2;
        logic [31:0] b, exp;
        logic        src;
        logic [3:0]  op;
        logic [31:0] im;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0)
                do_write(5'($urandom_range(0, 31)), $urandom());
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            src = 1'($urandom_range(0, 1));
            im = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40));
            op = ops[$urandom_range(0, 9)];
            set_ops(r1, r2, src, im, op);
            b = src ? im : model[r2];
            exp = ref_alu(model[r1], b, op);
            vectors++;
            if (readData1 !== model[r1] || readData2 !== model[r2] || result !== exp
                || zero !== (exp == 32'd0)) begin
                errors++;
                $display("FAIL random op=%b r1=x%0d r2=x%0d src=%b imm=%h: got %h/%h/%h z=%b want %h/%h/%h",
                         op, r1, r2, src, im, readData1, readData2, result, zero,
                         model[r1], model[r2], exp);
            end
        end
    endtask

    initial begin
        rst = 1'b0; write = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0; imm = '0; alu_src = 1'b0; alu_op = 4'b0010;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #12;
        vectors++;
        if (readData1 !== 32'd0 || result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL initial_reset: got %h/%h z=%b want 0/0 z=1", readData1, result, zero);
        end
        @(negedge clk);
        rst = 1'b1;
        test_write_read();
        test_x0();
        test_bypass();
        test_arith();
        test_imm_shifts();
        test_zero_undef();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
